pipelined_rca: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor. Splits a WIDTH-bit add

---
 rtl/rca_pkg.sv | 18 +
 rtl/fulladder.sv | 16 +
 rtl/rca_chunk.sv | 32 +++
 rtl/pipelined_rca.sv | 132 +++++++++++++
 tb/tb_pipelined_rca.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rca_pkg.sv
// Shared types and defaults for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

  // Operation select carried on in_sub
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;

  // Bits per pipeline chunk; guards the divide so a bad STAGES reaches the elaboration check
  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder built from fulladder cells.
// c_msb_in exposes the carry into the top bit so the last chunk can flag signed overflow.
module rca_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  // Ripple chain, bit 0 upward
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (s[i]),
      .cout (carry[i+1])
    );
  end

  assign cout     = carry[CHUNK];
  assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// Each stage adds one CHUNK of the operands using the carry registered by the previous
// stage. The running word s_q[k] holds finished sum chunks in its low part and the
// still-unprocessed A chunks in its high part, so the result is complete at the last stage.
module pipelined_rca
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  // Reject geometries that cannot be split into equal chunks
  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_rca: WIDTH=%0d must be a multiple of STAGES=%0d (STAGES >= 1)",
           WIDTH, STAGES);
  end

  // Global advance and operand entry
  logic              adv_c;
  logic [WIDTH-1:0]  b_entry_c;

  // Per-stage inputs (from the previous stage register or the input port)
  logic [WIDTH-1:0]  s_in_c   [STAGES];
  logic [WIDTH-1:0]  b_in_c   [STAGES];
  logic [STAGES-1:0] c_in_c;
  logic [STAGES-1:0] v_next_c;

  // Per-stage adder results
  logic [WIDTH-1:0]  s_next_c [STAGES];
  logic [STAGES-1:0] c_next_c;
  logic              c_msb_c  [STAGES];

  // Stage registers
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  s_q      [STAGES];
  logic [WIDTH-1:0]  b_q      [STAGES];
  logic              ovf_q;

  // Whole pipe moves when the last slot is empty or being drained
  assign adv_c    = ~v_q[STAGES-1] | out_ready;
  assign in_ready = adv_c;

  // Subtract as A + ~B + 1: invert B once at entry, the +1 is stage 0 carry-in
  assign b_entry_c = (op_e'(in_sub) == OP_SUB) ? ~in_b : in_b;

  // One chunk adder per stage, fed from the previous stage's registers
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] sum_c;
    logic [WIDTH-1:0] s_merge_c;

    if (k == 0) begin : g_first
      assign s_in_c[k]   = in_a;
      assign b_in_c[k]   = b_entry_c;
      assign c_in_c[k]   = in_sub;
      assign v_next_c[k] = in_valid;
    end else begin : g_rest
      assign s_in_c[k]   = s_q[k-1];
      assign b_in_c[k]   = b_q[k-1];
      assign c_in_c[k]   = c_q[k-1];
      assign v_next_c[k] = v_q[k-1];
    end

    rca_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .cin      (c_in_c[k]),
      .a        (s_in_c[k][k*CHUNK +: CHUNK]),
      .b        (b_in_c[k][k*CHUNK +: CHUNK]),
      .s        (sum_c),
      .cout     (c_next_c[k]),
      .c_msb_in (c_msb_c[k])
    );

    // Replace this stage's A chunk with its finished sum chunk
    always_comb begin
      s_merge_c                  = s_in_c[k];
      s_merge_c[k*CHUNK +: CHUNK] = sum_c;
    end

    assign s_next_c[k] = s_merge_c;
  end

  // Valid bits, running sum, carries and overflow flag; hold whenever adv_c is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= '0;
      end
    end else if (adv_c) begin
      v_q   <= v_next_c;
      c_q   <= c_next_c;
      ovf_q <= c_msb_c[STAGES-1] ^ c_next_c[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= s_next_c[k];
      end
    end
  end

  // Operand B skew registers travel with the op; contents are don't-care while invalid
  always_ff @(posedge clk) begin
    if (adv_c) begin
      for (int k = 0; k < STAGES; k++) begin
        b_q[k] <= b_in_c[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: directed 8-bit/2-stage vectors plus randomised
// 32-bit traffic at 1, 4 and 32 stages against a behavioural reference.
module tb_pipelined_rca;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  logic rst32  = 1'b1;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- 8-bit, 2-stage directed DUT ----------------
  logic       rst8, iv8, ir8, sub8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, sum8;

  pipelined_rca #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk       (clk),
    .rst       (rst8),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .in_a      (a8),
    .in_b      (b8),
    .in_sub    (sub8),
    .out_valid (ov8),
    .out_ready (or8),
    .out_sum   (sum8),
    .out_cout  (co8),
    .out_ovf   (of8)
  );

  // One op into an empty pipe; checks acceptance, latency, result and drain
  task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    iv8 = 1'b1; a8 = a; b8 = b; sub8 = sub; or8 = 1'b1;
    #1 check({tag, "_in_ready"}, 64'(ir8), 64'd1);
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd2);
    check({tag, "_sum"},  64'(sum8), 64'(es));
    check({tag, "_cout"}, 64'(co8),  64'(ec));
    check({tag, "_ovf"},  64'(of8),  64'(eo));
    @(posedge clk);
    #1 check({tag, "_drained"}, 64'(ov8), 64'd0);
  endtask

  // Stall test vectors: {a, b, sub} and hand-computed {ovf, cout, sum}
  logic [7:0] st_a   [6] = '{8'h10, 8'hF0, 8'h50, 8'h80, 8'h01, 8'h7F};
  logic [7:0] st_b   [6] = '{8'h20, 8'h20, 8'h60, 8'h80, 8'h01, 8'h7F};
  logic       st_sub [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
  logic [9:0] st_exp [6] = '{10'h030, 10'h110, 10'h0F0, 10'h300, 10'h100, 10'h2FE};

  // ---------------- 32-bit random DUTs at 1, 4, 32 stages ----------------
  function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
    longint     sa, sb, sr;
    logic [32:0] u;
    logic       c, o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      sr = sa - sb;
      u  = {1'b0, a} - {1'b0, b};
      c  = (a >= b);
    end else begin
      sr = sa + sb;
      u  = {1'b0, a} + {1'b0, b};
      c  = u[32];
    end
    o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {o, c, u[31:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int unsigned S = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
    logic        iv, ir, sub, ov, ordy, co, of;
    logic [31:0] a, b, sum;

    pipelined_rca #(.WIDTH(32), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst       (rst32),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_a      (a),
      .in_b      (b),
      .in_sub    (sub),
      .out_valid (ov),
      .out_ready (ordy),
      .out_sum   (sum),
      .out_cout  (co),
      .out_ovf   (of)
    );

    // Random traffic with a FIFO scoreboard; drain at the end
    initial begin
      logic [33:0] q [$];
      logic [33:0] e;
      iv = 1'b0; ordy = 1'b0; a = '0; b = '0; sub = 1'b0;
      repeat (5) @(negedge clk);
      for (int cyc = 0; cyc < 700; cyc++) begin
        @(negedge clk);
        if (cyc < 600) begin
          iv  = ($urandom_range(0, 3) != 0);
          a   = $urandom();
          b   = (cyc % 50 == 7) ? a : $urandom();
          sub = 1'(($urandom_range(0, 1)));
        end else begin
          iv = 1'b0;
        end
        ordy = (cyc >= 600) || ($urandom_range(0, 3) != 0);
        #1;
        if (ov && ordy) begin
          if (q.size() == 0) begin
            check($sformatf("rand_s%0d_spurious", S), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("rand_s%0d_result", S), {30'd0, of, co, sum}, {30'd0, e});
          end
        end
        if (iv && ir) q.push_back(ref_model(a, b, sub));
        if (cyc >= 600 && q.size() == 0 && !ov) break;
      end
      check($sformatf("rand_s%0d_left_in_pipe", S), 64'(q.size()), 64'd0);
      n_done++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int next_in, next_out, stale;
    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(ov8),  64'd0);
    check("reset_out_sum",   64'(sum8), 64'd0);
    check("reset_out_cout",  64'(co8),  64'd0);
    check("reset_out_ovf",   64'(of8),  64'd0);
    check("reset_in_ready",  64'(ir8),  64'd1);
    rst8 = 1'b0; rst32 = 1'b0;

    // Directed add/sub vectors
    run_op8("add_ff_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op8("add_7f_01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op8("sub_80_01",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op8("sub_05_07",  8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op8("sub_07_05",  8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op8("add_0f_01",  8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op8("add_3c_4b",  8'h3C, 8'h4B, 1'b0, 8'h87, 1'b0, 1'b1);
    run_op8("sub_00_00",  8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

    // Back-to-back ops with the consumer stalled for the first 4 cycles
    next_in = 0; next_out = 0;
    for (int cyc = 0; cyc < 40 && next_out < 6; cyc++) begin
      @(negedge clk);
      or8 = (cyc >= 4);
      iv8 = (next_in < 6);
      if (next_in < 6) begin
        a8 = st_a[next_in]; b8 = st_b[next_in]; sub8 = st_sub[next_in];
      end
      #1;
      if (cyc == 2 || cyc == 3) check("stall_in_ready", 64'(ir8), 64'd0);
      if (ov8) begin
        check($sformatf("stall_result%0d", next_out), {54'd0, of8, co8, sum8},
              {54'd0, st_exp[next_out]});
        if (or8) next_out++;
      end
      if (iv8 && ir8) next_in++;
    end
    check("stall_all_out", 64'(next_out), 64'd6);
    @(negedge clk);
    iv8 = 1'b0;
    #1 check("stall_empty", 64'(ov8), 64'd0);

    // Reset with two ops in flight
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34;
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b0;
    #1 check("midrst_pre_result", {54'd0, ov8, co8, sum8}, {54'd0, 2'b11, 8'hFE});
    rst8 = 1'b1;
    #1;
    check("midrst_out_valid", 64'(ov8),  64'd0);
    check("midrst_out_sum",   64'(sum8), 64'd0);
    check("midrst_out_cout",  64'(co8),  64'd0);
    check("midrst_out_ovf",   64'(of8),  64'd0);
    check("midrst_in_ready",  64'(ir8),  64'd1);
    @(negedge clk);
    rst8 = 1'b0; or8 = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (ov8) stale++;
    end
    check("midrst_no_stale", 64'(stale), 64'd0);
    run_op8("after_rst", 8'h21, 8'h11, 1'b0, 8'h32, 1'b0, 1'b0);

    // Wait for random streams, bounded
    for (int t = 0; t < 5000 && n_done < 3; t++) @(posedge clk);
    check("random_streams_done", 64'(n_done), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
